// File: rtl/dcache_pkg.sv
// Shared types and helpers for the d_cache_v2 direct-mapped, write-through data cache.
// Holds the controller state encoding, strobe legality and store lane placement.
package dcache_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOOKUP = 2'd1,
        ST_REFILL = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // Reads must be full-word; stores may be a byte, an aligned halfword or a word.
    function automatic logic strb_legal(input logic we, input logic [3:0] strb);
        logic ok;
        ok = 1'b0;
        if (!we) begin
            ok = (strb == 4'b1111);
        end else begin
            case (strb)
                4'b0001, 4'b0010, 4'b0100, 4'b1000,
                4'b0011, 4'b1100, 4'b1111: ok = 1'b1;
                default:                   ok = 1'b0;
            endcase
        end
        return ok;
    endfunction

    // Store data arrives right-aligned; replicate it across lanes and keep only strobed bytes.
    function automatic logic [31:0] place_lanes(input logic [3:0] strb, input logic [31:0] wdata);
        logic [31:0] rep;
        logic [31:0] mask;
        case (strb)
            4'b0001, 4'b0010, 4'b0100, 4'b1000: rep = {4{wdata[7:0]}};
            4'b0011, 4'b1100:                   rep = {2{wdata[15:0]}};
            default:                            rep = wdata;
        endcase
        mask = {{8{strb[3]}}, {8{strb[2]}}, {8{strb[1]}}, {8{strb[0]}}};
        return rep & mask;
    endfunction

endpackage

// File: rtl/d_cache_v2_if.sv
// Core request/response and backing-memory bus of d_cache_v2.
// The cache uses the slave view; the core/memory environment uses the master view.
interface d_cache_v2_if #(
    parameter int ADDR_W = 14
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [3:0]        req_wstrb;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wstrb;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    modport master (
        output req_valid, req_we, req_wstrb, req_addr, req_wdata,
        output mem_ack, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );

    modport slave (
        input  req_valid, req_we, req_wstrb, req_addr, req_wdata,
        input  mem_ack, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata, mem_wstrb
    );
endinterface

// File: rtl/dcache_array.sv
// Tag, valid and byte-lane data storage for d_cache_v2 with registered reads.
// Valid bits live in flops so a flush can clear every line in a single cycle.
module dcache_array #(
    parameter int  NUM_SETS = 256,
    parameter int  TAG_W    = 4,
    localparam int IDX_W    = $clog2(NUM_SETS)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush_clr,
    input  logic [IDX_W-1:0] rd_index,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic [IDX_W-1:0] wr_index,
    input  logic             wr_tag_en,
    input  logic [TAG_W-1:0] wr_tag,
    input  logic [3:0]       wr_be,
    input  logic [31:0]      wr_data
);
    logic [NUM_SETS-1:0] valid_reg;
    logic                rd_valid_reg;
    logic [TAG_W-1:0]    tag_mem [NUM_SETS];
    logic [TAG_W-1:0]    rd_tag_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_reg    <= '0;
            rd_valid_reg <= 1'b0;
        end else begin
            if (flush_clr) begin
                valid_reg <= '0;
            end else if (wr_tag_en) begin
                valid_reg[wr_index] <= 1'b1;
            end
            rd_valid_reg <= valid_reg[rd_index];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_tag_en) begin
            tag_mem[wr_index] <= wr_tag;
        end
        rd_tag_reg <= tag_mem[rd_index];
    end

    assign rd_valid = rd_valid_reg;
    assign rd_tag   = rd_tag_reg;

    // One narrow RAM per byte lane gives the per-byte write enables.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [7:0] lane_mem [NUM_SETS];
            logic [7:0] lane_q_reg;

            always_ff @(posedge clk) begin
                if (wr_be[gi]) begin
                    lane_mem[wr_index] <= wr_data[8*gi +: 8];
                end
                lane_q_reg <= lane_mem[rd_index];
            end

            assign rd_data[8*gi +: 8] = lane_q_reg;
        end
    endgenerate

endmodule

// File: rtl/d_cache_v2.sv
// Direct-mapped, write-through, no-write-allocate data cache with one 32-bit word per set.
// Optional read hit/miss counters are built when DCACHE_STATS_EN is defined.
module d_cache_v2
    import dcache_pkg::*;
#(
    parameter int ADDR_W   = 14,
    parameter int NUM_SETS = 256
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    d_cache_v2_if.slave     bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]     hit_cnt,
    output logic [31:0]     miss_cnt
`endif
);
    localparam int IDX_W  = $clog2(NUM_SETS);
    localparam int LINE_W = ADDR_W - 2;
    localparam int TAG_W  = LINE_W - IDX_W;

    state_t              state_reg, state_next;
    logic                we_reg;
    logic                legal_reg;
    logic                hit_reg, hit_next;
    logic [3:0]          wstrb_reg;
    logic [LINE_W-1:0]   line_addr_reg;
    logic [31:0]         wdata_reg;
    logic                accept;

    logic [IDX_W-1:0]    index_reg;
    logic [TAG_W-1:0]    tag_reg;
    logic [ADDR_W-1:0]   word_addr;
    logic                lookup_hit;

    logic                flush_clr;
    logic [IDX_W-1:0]    rd_index;
    logic                rd_valid;
    logic [TAG_W-1:0]    rd_tag;
    logic [31:0]         rd_data;
    logic                wr_tag_en;
    logic [3:0]          wr_be;
    logic [31:0]         wr_data;

    logic                unused_offset;

    assign unused_offset = ^bus.req_addr[1:0];

    assign index_reg  = line_addr_reg[IDX_W-1:0];
    assign tag_reg    = line_addr_reg[LINE_W-1:IDX_W];
    assign word_addr  = {line_addr_reg, 2'b00};
    assign lookup_hit = rd_valid && (rd_tag == tag_reg);

    // The array is read with the live request index so the line is ready during LOOKUP.
    assign rd_index = bus.req_addr[IDX_W+1:2];

    dcache_array #(
        .NUM_SETS (NUM_SETS),
        .TAG_W    (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush_clr (flush_clr),
        .rd_index  (rd_index),
        .rd_valid  (rd_valid),
        .rd_tag    (rd_tag),
        .rd_data   (rd_data),
        .wr_index  (index_reg),
        .wr_tag_en (wr_tag_en),
        .wr_tag    (tag_reg),
        .wr_be     (wr_be),
        .wr_data   (wr_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= ST_IDLE;
            we_reg        <= 1'b0;
            legal_reg     <= 1'b0;
            hit_reg       <= 1'b0;
            wstrb_reg     <= '0;
            line_addr_reg <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg <= state_next;
            hit_reg   <= hit_next;
            if (accept) begin
                we_reg        <= bus.req_we;
                legal_reg     <= strb_legal(bus.req_we, bus.req_wstrb);
                wstrb_reg     <= bus.req_wstrb;
                line_addr_reg <= bus.req_addr[ADDR_W-1:2];
                wdata_reg     <= place_lanes(bus.req_wstrb, bus.req_wdata);
            end
        end
    end

    always_comb begin
        state_next     = state_reg;
        hit_next       = hit_reg;
        accept         = 1'b0;
        flush_clr      = 1'b0;
        wr_tag_en      = 1'b0;
        wr_be          = '0;
        wr_data        = '0;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.rsp_err    = 1'b0;
        bus.rsp_rdata  = '0;
        bus.mem_req    = 1'b0;
        bus.mem_we     = 1'b0;
        bus.mem_addr   = '0;
        bus.mem_wdata  = '0;
        bus.mem_wstrb  = '0;

        case (state_reg)
            ST_IDLE: begin
                // Flush takes priority over a request arriving in the same cycle.
                bus.req_ready = !flush;
                flush_clr     = flush;
                accept        = bus.req_valid && !flush;
                if (accept) begin
                    state_next = ST_LOOKUP;
                end
            end

            ST_LOOKUP: begin
                hit_next = lookup_hit;
                if (!legal_reg) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_err   = 1'b1;
                    state_next    = ST_IDLE;
                end else if (we_reg) begin
                    state_next = ST_WRITE;
                end else if (lookup_hit) begin
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = rd_data;
                    state_next    = ST_IDLE;
                end else begin
                    state_next = ST_REFILL;
                end
            end

            ST_REFILL: begin
                bus.mem_req   = 1'b1;
                bus.mem_addr  = word_addr;
                bus.mem_wstrb = 4'b1111;
                if (bus.mem_ack) begin
                    wr_tag_en     = 1'b1;
                    wr_be         = 4'b1111;
                    wr_data       = bus.mem_rdata;
                    bus.rsp_valid = 1'b1;
                    bus.rsp_rdata = bus.mem_rdata;
                    state_next    = ST_IDLE;
                end
            end

            ST_WRITE: begin
                bus.mem_req   = 1'b1;
                bus.mem_we    = 1'b1;
                bus.mem_addr  = word_addr;
                bus.mem_wdata = wdata_reg;
                bus.mem_wstrb = wstrb_reg;
                if (bus.mem_ack) begin
                    // Write-through without allocation: only a resident line is updated.
                    wr_be         = hit_reg ? wstrb_reg : 4'b0000;
                    wr_data       = wdata_reg;
                    bus.rsp_valid = 1'b1;
                    state_next    = ST_IDLE;
                end
            end

            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

`ifdef DCACHE_STATS_EN
    logic        stat_rd;
    logic [31:0] hit_cnt_reg;
    logic [31:0] miss_cnt_reg;

    assign stat_rd = (state_reg == ST_LOOKUP) && legal_reg && !we_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_reg  <= '0;
            miss_cnt_reg <= '0;
        end else if (stat_rd) begin
            if (lookup_hit && (hit_cnt_reg != 32'hFFFF_FFFF)) begin
                hit_cnt_reg <= hit_cnt_reg + 32'd1;
            end
            if (!lookup_hit && (miss_cnt_reg != 32'hFFFF_FFFF)) begin
                miss_cnt_reg <= miss_cnt_reg + 32'd1;
            end
        end
    end

    assign hit_cnt  = hit_cnt_reg;
    assign miss_cnt = miss_cnt_reg;
`endif

endmodule

// File: doc/d_cache_v2.md
D_CACHE_V2 -- requirements
Module: d_cache_v2

Interface
REQ-001 Parameter ADDR_W, default 14; byte-address width of the core request.
REQ-002 Parameter NUM_SETS, default 256; direct-mapped sets of one 32-bit word each, power of two, minimum 2.
REQ-003 Port clk, input, 1; single clock for all logic.
REQ-004 Port rst_n, input, 1; asynchronous active-low reset.
REQ-005 Ports req_valid / req_ready, input / output, 1 each; core request handshake.
REQ-006 Ports req_we (input, 1), req_wstrb (input, 4), req_addr (input, ADDR_W), req_wdata (input, 32); store data is right-aligned.
REQ-007 Ports rsp_valid (output, 1), rsp_rdata (output, 32), rsp_err (output, 1); one-cycle response pulse.
REQ-008 Ports mem_req (output, 1), mem_we (output, 1), mem_addr (output, ADDR_W), mem_wdata (output, 32), mem_wstrb (output, 4); backing-memory request.
REQ-009 Ports mem_ack (input, 1), mem_rdata (input, 32); backing-memory completion.
REQ-010 Port flush (input, 1); invalidate all lines.

Function
REQ-011 Address split: offset = addr[1:0] (ignored), index = next log2(NUM_SETS) bits, tag = the remaining upper bits.
REQ-012 States: IDLE, LOOKUP, REFILL, WRITE.
REQ-013 req_ready = 1 only in IDLE with flush low; a request is accepted when req_valid & req_ready, and it is registered and moves the FSM to LOOKUP.
REQ-014 Legal strobes: 0001, 0010, 0100, 1000, 0011, 1100, 1111; only 1111 is legal for reads.
REQ-015 Store lane placement: a single byte at lane k takes wdata[7:0]; a halfword at 1100 takes wdata[15:0] into bytes 3:2; 1111 takes the full word.
REQ-016 LOOKUP, illegal strobe: rsp_valid=1, rsp_err=1, rsp_rdata=0, no memory access, no array change; then IDLE.
REQ-017 LOOKUP, read hit (valid & tag match): rsp_valid=1, rsp_rdata=line data; then IDLE; hit latency is 2 cycles from acceptance.
REQ-018 LOOKUP, read miss: go to REFILL; mem_req=1, mem_we=0, mem_wstrb=1111, mem_addr={tag,index,2'b00}.
REQ-019 REFILL on mem_ack: write mem_rdata into the line, set valid, store tag; assert rsp_valid with rsp_rdata=mem_rdata in the same cycle; then IDLE.
REQ-020 LOOKUP, legal write: go to WRITE (write-through, no-write-allocate); mem_we=1, mem_wstrb=req_wstrb, mem_wdata=lane-placed data.
REQ-021 WRITE on mem_ack: on hit, byte-merge the lane-placed data into the line under the strobe; on miss, leave the array unchanged; rsp_valid=1, rsp_err=0; then IDLE.
REQ-022 mem_req and all mem_* outputs are held stable from assertion until the mem_ack cycle inclusive; mem_ack outside REFILL/WRITE is ignored.
REQ-023 Flush high in IDLE: clear all valid bits in one cycle; req_ready=0 that cycle; flush is ignored in any other state.
REQ-024 A request and flush that are high in the same IDLE cycle: flush wins and the request is not accepted.
REQ-025 rsp_rdata is 0 whenever rsp_valid=0.

Reset
REQ-026 Reset returns to IDLE and clears all valid bits; mem_req, rsp_valid, rsp_err and rsp_rdata go to 0; req_ready is 1 after release.
REQ-027 Reset mid-REFILL/WRITE abandons the transaction and issues no response; a later mem_ack is ignored.

Configuration
REQ-028 Macro DCACHE_STATS_EN defined: 32-bit output ports hit_cnt and miss_cnt (saturating, reset 0) count read hits and read misses.
REQ-029 Macro DCACHE_STATS_EN undefined: those ports and counters are absent; all other behaviour is identical.

Structure
REQ-030 Package dcache_pkg holds the state enum, the legal-strobe function, and the lane-placement function.
REQ-031 Sub-module dcache_array (tag, valid and data storage with byte-write enables and a flush-clear input) is instantiated once.

Verification
REQ-032 Read 0x0040 cold: REFILL issued with mem_addr=0x0040; mem_rdata=0xDEADBEEF -> rsp_rdata=0xDEADBEEF; repeat read -> hit at 2 cycles, no mem_req.
REQ-033 With 0x0040 cached as 0xDEADBEEF, store wstrb=0010 wdata=0x55 -> mem_wdata=0x00005500; next read -> 0xDEAD55EF.
REQ-034 Store wstrb=0101 -> rsp_err=1, mem_req never asserted; read with wstrb=0011 -> rsp_err=1.
REQ-035 Fill 0x0040, then read 0x0440 (same index, different tag) -> miss/refill; read 0x0040 again -> miss.
REQ-036 Flush held high with req_valid high -> req_ready=0 for that cycle; next read of 0x0040 -> miss.
REQ-037 Reset asserted during REFILL, then a late mem_ack -> no rsp_valid; FSM in IDLE; read 0x0040 -> miss.
